// File: rtl/snes_pad_reader_pkg.sv
// snes_pad_pkg: shared definitions for the joypad reader.
//  - pad_state_e : frame sequencer states
//  - BTN_*       : bit positions of each button in the O_BUTTONS layout
//  - SER_TO_P1   : serial bit index -> O_BUTTONS bit index map
//  - ser_to_p1() : applies the map to a full serial frame
package snes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } pad_state_e;

  localparam logic [2:0] BTN_START  = 3'd7;
  localparam logic [2:0] BTN_SELECT = 3'd6;
  localparam logic [2:0] BTN_B      = 3'd5;
  localparam logic [2:0] BTN_A      = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd2;
  localparam logic [2:0] BTN_LEFT   = 3'd1;
  localparam logic [2:0] BTN_RIGHT  = 3'd0;

  // Entry for serial bit i lives at [3*i +: 3]; serial order is
  // A, B, SELECT, START, UP, DOWN, LEFT, RIGHT (bit 0 first).
  localparam logic [23:0] SER_TO_P1 = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP,
                                       BTN_START, BTN_SELECT, BTN_B, BTN_A};

  localparam logic [3:0] STABLE_MAX = 4'd15;

  // Pure wiring permutation from serial frame to O_BUTTONS layout.
  function automatic logic [7:0] ser_to_p1(input logic [7:0] ser);
    logic [7:0] p1;
    p1 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      p1[SER_TO_P1[3*i +: 3]] = ser[i];
    end
    return p1;
  endfunction

endpackage

// File: rtl/snes_pad_reader_if.sv
// snes_pad_if: pad-side serial lines plus the debounced button bus.
//  I_DATA    pad serial data (0 = pressed), driven by the pad
//  O_LATCH   latch strobe to the pad
//  O_PULSE   shift clock to the pad
//  O_BUTTONS debounced buttons, 1 = pressed
//  O_UPDATE  one-cycle pulse when O_BUTTONS changes
//  O_BUSY    frame in progress
// master = the reader, slave = pad + P1 consumer side.
interface snes_pad_if;
  logic       I_DATA;
  logic       O_LATCH;
  logic       O_PULSE;
  logic [7:0] O_BUTTONS;
  logic       O_UPDATE;
  logic       O_BUSY;

  modport master (
    input  I_DATA,
    output O_LATCH, O_PULSE, O_BUTTONS, O_UPDATE, O_BUSY
  );

  modport slave (
    output I_DATA,
    input  O_LATCH, O_PULSE, O_BUTTONS, O_UPDATE, O_BUSY
  );
endinterface

// File: rtl/snes_pad_reader_tick.sv
// snes_pad_tick: divide-by-TICK_DIV phase tick generator.
//  I_CLK   clock
//  I_RESET synchronous active-high reset
//  clr     restarts the division so the next tick is TICK_DIV cycles away
//  tick    high for one cycle at terminal count (TICK_DIV-1)
module snes_pad_tick #(
  parameter int TICK_DIV = 200
) (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo-TICK_DIV counter, restarted by clr.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == TICK_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = (cnt_r == TICK_LAST);

endmodule

// File: rtl/snes_pad_reader.sv
// snes_pad_reader: polls an NES-style serial pad, debounces the 8 buttons
// and presents them active-high in the P1 layout.
//  I_CLK    system clock
//  I_RESET  synchronous active-high reset
//  pad      snes_pad_if.master: I_DATA in; O_LATCH, O_PULSE, O_BUTTONS,
//           O_UPDATE, O_BUSY out (all outputs registered)
module snes_pad_reader
  import snes_pad_pkg::*;
#(
  parameter int TICK_DIV = 200,
  parameter int POLL_DIV = 550000,
  parameter int DEBOUNCE = 2
) (
  input logic         I_CLK,
  input logic         I_RESET,
  snes_pad_if.master  pad
);

  localparam int PW = $clog2(POLL_DIV);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [3:0]    DEB_TH    = 4'(DEBOUNCE);

  logic          data_meta_r;
  logic          data_sync_r;
  logic          pressed_s;
  logic [PW-1:0] poll_cnt_r;
  logic          poll_wrap_s;
  logic          frame_start_s;
  logic          tick_s;
  pad_state_e    state_r;
  logic          latch_r;
  logic          pulse_r;
  logic          busy_r;
  logic          update_r;
  logic          latch_half_r;
  logic [2:0]    bit_r;
  logic [7:0]    shift_r;
  logic [7:0]    prev_r;
  logic [3:0]    stable_r;
  logic [7:0]    buttons_r;
  logic [7:0]    frame_s;
  logic [3:0]    stable_next_s;
  logic          commit_s;

  // Two-flop synchroniser; resets to "released" (line high).
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      data_meta_r <= pad.I_DATA;
      data_sync_r <= data_meta_r;
    end
  end

  assign pressed_s = ~data_sync_r;

  // Frame-rate poll counter, 0..POLL_DIV-1.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      poll_cnt_r <= '0;
    end else if (poll_wrap_s) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + PW'(1);
    end
  end

  assign poll_wrap_s = (poll_cnt_r == POLL_LAST);
  // A wrap while busy is ignored, so only an idle wrap restarts the tick.
  assign frame_start_s = poll_wrap_s && (state_r == IDLE);

  snes_pad_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .clr     (frame_start_s),
    .tick    (tick_s)
  );

  // Debounce decision for the frame held in shift_r (used only in DONE).
  always_comb begin
    frame_s       = ser_to_p1(shift_r);
    stable_next_s = 4'd1;
    if (frame_s == prev_r) begin
      if (stable_r == STABLE_MAX) begin
        stable_next_s = STABLE_MAX;
      end else begin
        stable_next_s = stable_r + 4'd1;
      end
    end else begin
      stable_next_s = 4'd1;
    end
    commit_s = (stable_next_s >= DEB_TH) && (frame_s != buttons_r);
  end

  // Frame sequencer: latch, 8 samples with 7 shift pulses, then debounce.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_r      <= IDLE;
      latch_r      <= 1'b0;
      pulse_r      <= 1'b0;
      busy_r       <= 1'b0;
      update_r     <= 1'b0;
      latch_half_r <= 1'b0;
      bit_r        <= 3'd0;
      shift_r      <= 8'h00;
      prev_r       <= 8'h00;
      stable_r     <= 4'd0;
      buttons_r    <= 8'h00;
    end else begin
      update_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (poll_wrap_s) begin
            state_r      <= LATCH;
            latch_r      <= 1'b1;
            busy_r       <= 1'b1;
            latch_half_r <= 1'b0;
          end
        end
        LATCH: begin
          // Latch spans two ticks; latch_half_r marks the first one.
          if (tick_s) begin
            if (latch_half_r) begin
              state_r <= LOW;
              latch_r <= 1'b0;
              bit_r   <= 3'd0;
            end else begin
              latch_half_r <= 1'b1;
            end
          end
        end
        LOW: begin
          if (tick_s) begin
            shift_r[bit_r] <= pressed_s;
            if (bit_r == 3'd7) begin
              state_r <= DONE;
            end else begin
              state_r <= HIGH;
              pulse_r <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (tick_s) begin
            pulse_r <= 1'b0;
            bit_r   <= bit_r + 3'd1;
            state_r <= LOW;
          end
        end
        DONE: begin
          stable_r <= stable_next_s;
          prev_r   <= frame_s;
          if (commit_s) begin
            buttons_r <= frame_s;
            update_r  <= 1'b1;
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          latch_r <= 1'b0;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pad.O_LATCH   = latch_r;
  assign pad.O_PULSE   = pulse_r;
  assign pad.O_BUTTONS = buttons_r;
  assign pad.O_UPDATE  = update_r;
  assign pad.O_BUSY    = busy_r;

endmodule

// File: tb/tb_snes_pad_reader.sv
// tb_snes_pad_reader: directed bench for snes_pad_reader with a behavioural
// shift-register pad (TICK_DIV=4, POLL_DIV=200, DEBOUNCE=2).
module tb_snes_pad_reader;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc_cnt;

  snes_pad_if pad_if ();

  snes_pad_reader #(.TICK_DIV(4), .POLL_DIV(200), .DEBOUNCE(2)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .pad     (pad_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural pad: latch reloads, each rising shift clock advances one bit.
  logic [7:0] pad_ser;
  bit         pad_conn;
  int         pad_idx;
  logic       pulse_d;

  always @(posedge clk) begin
    if (pad_if.O_LATCH) pad_idx <= 0;
    else if (pad_if.O_PULSE && !pulse_d) pad_idx <= pad_idx + 1;
    pulse_d <= pad_if.O_PULSE;
  end

  assign pad_if.I_DATA = !pad_conn ? 1'b1 :
                         (pad_idx < 8) ? ~pad_ser[pad_idx[2:0]] : 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-frame measurements
  int fr_upd, fr_lat, fr_edges, fr_busy, fr_start;
  int fr_pmin, fr_pmax, fr_lmin, fr_lmax;
  bit fr_done;

  // Waits for the next frame to start and finish, measuring its waveform.
  task automatic run_frame();
    bit seen;
    bit prev_p;
    int hrun, lrun;
    seen = 0; prev_p = 0; hrun = 0; lrun = 0;
    fr_upd = 0; fr_lat = 0; fr_edges = 0; fr_busy = 0; fr_start = 0;
    fr_done = 0; fr_pmin = 1000; fr_pmax = 0; fr_lmin = 1000; fr_lmax = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pad_if.O_UPDATE) fr_upd++;
      if (pad_if.O_LATCH) fr_lat++;
      if (pad_if.O_PULSE) begin
        if (!prev_p) begin
          if (fr_edges > 0) begin
            if (lrun < fr_lmin) fr_lmin = lrun;
            if (lrun > fr_lmax) fr_lmax = lrun;
          end
          fr_edges++;
          hrun = 0;
        end
        hrun++;
      end else begin
        if (prev_p) begin
          if (hrun < fr_pmin) fr_pmin = hrun;
          if (hrun > fr_pmax) fr_pmax = hrun;
          lrun = 0;
        end
        lrun++;
      end
      prev_p = pad_if.O_PULSE;
      if (pad_if.O_BUSY) begin
        if (!seen) fr_start = cyc_cnt;
        seen = 1;
        fr_busy++;
      end else if (seen) begin
        fr_done = 1;
        break;
      end
    end
    check("frame_end_timeout", int'(fr_done), 1);
  endtask

  task automatic check_wave(input string tag);
    check({tag, "_latch_cycles"}, fr_lat, 8);
    check({tag, "_pulse_count"}, fr_edges, 7);
    check({tag, "_pulse_high_min"}, fr_pmin, 4);
    check({tag, "_pulse_high_max"}, fr_pmax, 4);
    check({tag, "_pulse_low_min"}, fr_lmin, 4);
    check({tag, "_pulse_low_max"}, fr_lmax, 4);
    check({tag, "_busy_cycles"}, fr_busy, 69);
  endtask

  typedef struct {
    string      name;
    logic [7:0] ser;
    bit         conn;
    int         frames;
    logic [7:0] exp_btn;
    int         exp_upd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int rel;
    int first_start;
    int upd;
    int edges;
    bit hit;

    n_checks = 0; n_errors = 0; cyc_cnt = 0;
    pad_idx = 0; pulse_d = 1'b0;
    pad_ser = 8'h00; pad_conn = 1'b1;

    vecs[0]  = '{"a_held",          8'h01, 1'b1, 2, 8'h10, 1};
    vecs[1]  = '{"a_still_held",    8'h01, 1'b1, 1, 8'h10, 0};
    vecs[2]  = '{"start_right",     8'h88, 1'b1, 2, 8'h81, 1};
    vecs[3]  = '{"release_frame1",  8'h00, 1'b1, 1, 8'h81, 0};
    vecs[4]  = '{"release_frame2",  8'h00, 1'b1, 1, 8'h00, 1};
    vecs[5]  = '{"b_glitch",        8'h02, 1'b1, 1, 8'h00, 0};
    vecs[6]  = '{"after_glitch",    8'h00, 1'b1, 2, 8'h00, 0};
    vecs[7]  = '{"up_left",         8'h50, 1'b1, 2, 8'h06, 1};
    vecs[8]  = '{"disconnected",    8'h00, 1'b0, 2, 8'h00, 1};
    vecs[9]  = '{"select_down",     8'h24, 1'b1, 2, 8'h48, 1};
    vecs[10] = '{"all_pressed",     8'hFF, 1'b1, 2, 8'hFF, 1};

    // Reset held 10 cycles
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_buttons", int'(pad_if.O_BUTTONS), 8'h00);
    check("rst_latch",   int'(pad_if.O_LATCH), 0);
    check("rst_pulse",   int'(pad_if.O_PULSE), 0);
    check("rst_update",  int'(pad_if.O_UPDATE), 0);
    check("rst_busy",    int'(pad_if.O_BUSY), 0);
    rst = 1'b0;
    rel = cyc_cnt;

    // First two frames with nothing pressed: waveform and frame spacing
    run_frame();
    check("first_frame_offset", fr_start - rel, 200);
    check_wave("f1");
    check("f1_updates", fr_upd, 0);
    first_start = fr_start;
    run_frame();
    check("frame_period", fr_start - first_start, 200);
    check_wave("f2");
    check("f2_buttons", int'(pad_if.O_BUTTONS), 8'h00);

    // Table-driven button sequences
    for (int v = 0; v < 11; v++) begin
      pad_ser  = vecs[v].ser;
      pad_conn = vecs[v].conn;
      upd = 0;
      for (int f = 0; f < vecs[v].frames; f++) begin
        run_frame();
        upd += fr_upd;
      end
      check({vecs[v].name, "_buttons"}, int'(pad_if.O_BUTTONS), int'(vecs[v].exp_btn));
      check({vecs[v].name, "_updates"}, upd, vecs[v].exp_upd);
    end

    // Reset during the HIGH phase of bit 3 (4th shift pulse)
    edges = 0; hit = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pad_if.O_PULSE && !pulse_d) begin
        edges++;
        if (edges == 4) begin
          hit = 1;
          break;
        end
      end
    end
    check("midframe_pulse_wait", int'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulse",   int'(pad_if.O_PULSE), 0);
    check("midrst_latch",   int'(pad_if.O_LATCH), 0);
    check("midrst_buttons", int'(pad_if.O_BUTTONS), 8'h00);
    check("midrst_busy",    int'(pad_if.O_BUSY), 0);
    check("midrst_update",  int'(pad_if.O_UPDATE), 0);
    rst = 1'b0;
    rel = cyc_cnt;
    run_frame();
    check("post_rst_offset", fr_start - rel, 200);
    check_wave("post_rst");
    check("post_rst_buttons", int'(pad_if.O_BUTTONS), 8'h00);
    check("post_rst_updates", fr_upd, 0);
    run_frame();
    check("post_rst2_buttons", int'(pad_if.O_BUTTONS), 8'hFF);
    check("post_rst2_updates", fr_upd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
